// File: rtl/mpc_types.sv
// Shared cache-op encodings and helpers for the issue / SRAM-controller path.
package mpc_types;

    // Number of xbar response channels, each with its own credit pool.
    localparam int XBAR_CHN_NUM = 3;

    typedef enum logic [2:0] {
        CACHE_OP_NOP         = 3'd0,
        CACHE_OP_LOAD        = 3'd1,
        CACHE_OP_LOAD_REFILL = 3'd2,
        CACHE_OP_STORE       = 3'd3,
        CACHE_OP_STORE_WB    = 3'd4
    } cache_op_e;

    // Load-class ops return data over the xbar and therefore consume a credit.
    function automatic logic is_load(input logic [2:0] op);
        return (op == CACHE_OP_LOAD) || (op == CACHE_OP_LOAD_REFILL);
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return (op == CACHE_OP_STORE) || (op == CACHE_OP_STORE_WB);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int NumReq = 2,
    parameter int IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o
);

    logic found;
    int   j;

    // Walk the requesters starting at the pointer; first hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < NumReq; k++) begin
            j = (int'(ptr_i) + k) % NumReq;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/isu_rc_arbiter.sv
// Round-robin arbiter sharing the SRAM-controller request port among the
// issue sources. Load-class requests are gated by per-channel xbar credits.
// One registered output stage feeds d_rc_*.
// Optional feature macro: MPC_RC_ARB_PERF_EN (per-requester stall counters).
module isu_rc_arbiter
    import mpc_types::*;
#(
    parameter int NumReq    = 2,
    parameter int SetWidth  = 8,
    parameter int WayWidth  = 3,
    parameter int WbufWidth = 4,
    parameter int RobWidth  = 5,
    parameter int CrdtMax   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NumReq-1:0]              req_valid,
    output logic [NumReq-1:0]              req_ready,
    input  logic [3*NumReq-1:0]            req_channel_1hot_id,
    input  logic [3*NumReq-1:0]            req_op,
    input  logic [RobWidth*NumReq-1:0]     req_rob_id,
    input  logic [SetWidth*NumReq-1:0]     req_set,
    input  logic [WayWidth*NumReq-1:0]     req_way,
    input  logic [WbufWidth*NumReq-1:0]    req_wbuf_id,
    input  logic [2:0]                     u_xbar_crdt_rtn,
    output logic                           d_rc_valid,
    input  logic                           d_rc_ready,
    output logic [2:0]                     d_rc_channel_1hot_id,
    output logic [RobWidth-1:0]            d_rc_rob_id,
    output logic [2:0]                     d_rc_op,
    output logic [SetWidth-1:0]            d_rc_set,
    output logic [WayWidth-1:0]            d_rc_way,
    output logic [WbufWidth-1:0]           d_rc_wbuf_id,
    output logic [$clog2(NumReq)-1:0]      d_rc_grant_id,
    output logic [8:0]                     crdt_avail,
    output logic                           crdt_err,
    output logic [16*NumReq-1:0]           perf_stall_cnt
);

    localparam int          IdxW     = $clog2(NumReq);
    localparam logic [2:0]  CRDT_MAX = 3'(CrdtMax);

    logic [XBAR_CHN_NUM-1:0][2:0] crdt_q, crdt_d;
    logic                         crdt_err_q, crdt_err_d;
    logic [IdxW-1:0]              ptr_q, ptr_d;

    logic [NumReq-1:0]            elig, gnt;
    logic [IdxW-1:0]              gnt_idx;
    logic                         can_load, acc;
    logic [XBAR_CHN_NUM-1:0]      crdt_zero, crdt_dec;

    logic [2:0]                   win_op, win_ch;
    logic [RobWidth-1:0]          win_rob;
    logic [SetWidth-1:0]          win_set;
    logic [WayWidth-1:0]          win_way;
    logic [WbufWidth-1:0]         win_wbuf;

    logic                         vld_q;
    logic [2:0]                   op_q, ch_q;
    logic [RobWidth-1:0]          rob_q;
    logic [SetWidth-1:0]          set_q;
    logic [WayWidth-1:0]          way_q;
    logic [WbufWidth-1:0]         wbuf_q;
    logic [IdxW-1:0]              gid_q;

    for (genvar c = 0; c < XBAR_CHN_NUM; c++) begin : g_zero
        assign crdt_zero[c] = (crdt_q[c] == 3'd0);
    end

    // A load is blocked if any channel it targets has no credit left;
    // a zero-hot channel never blocks.
    for (genvar i = 0; i < NumReq; i++) begin : g_elig
        assign elig[i] = req_valid[i] &
                         ~(is_load(req_op[3*i +: 3]) &
                           (|(req_channel_1hot_id[3*i +: 3] & crdt_zero)));
    end

    rr_arbiter #(.NumReq(NumReq), .IdxW(IdxW)) u_rr (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign can_load  = ~vld_q | d_rc_ready;
    assign req_ready = can_load ? gnt : '0;
    assign acc       = |req_ready;

    assign win_op   = req_op[3*int'(gnt_idx) +: 3];
    assign win_ch   = req_channel_1hot_id[3*int'(gnt_idx) +: 3];
    assign win_rob  = req_rob_id[RobWidth*int'(gnt_idx) +: RobWidth];
    assign win_set  = req_set[SetWidth*int'(gnt_idx) +: SetWidth];
    assign win_way  = req_way[WayWidth*int'(gnt_idx) +: WayWidth];
    assign win_wbuf = req_wbuf_id[WbufWidth*int'(gnt_idx) +: WbufWidth];

    assign crdt_dec = (acc && is_load(win_op)) ? win_ch : '0;

    // Pointer advances past the winner only on an actual accept.
    always_comb begin
        ptr_d = ptr_q;
        if (acc) ptr_d = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Credit bookkeeping: take on load accept, give on return, both cancel;
    // a return at the ceiling is dropped and flagged.
    always_comb begin
        crdt_d     = crdt_q;
        crdt_err_d = crdt_err_q;
        for (int c = 0; c < XBAR_CHN_NUM; c++) begin
            if (u_xbar_crdt_rtn[c] && !crdt_dec[c]) begin
                if (crdt_q[c] == CRDT_MAX) crdt_err_d = 1'b1;
                else                       crdt_d[c]  = crdt_q[c] + 3'd1;
            end else if (crdt_dec[c] && !u_xbar_crdt_rtn[c]) begin
                crdt_d[c] = crdt_q[c] - 3'd1;
            end
        end
    end

    // Pointer and credit state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            crdt_q     <= {XBAR_CHN_NUM{CRDT_MAX}};
            crdt_err_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            crdt_q     <= crdt_d;
            crdt_err_q <= crdt_err_d;
        end
    end

    // Output stage: reload whenever empty or draining; payload only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            op_q   <= '0;
            ch_q   <= '0;
            rob_q  <= '0;
            set_q  <= '0;
            way_q  <= '0;
            wbuf_q <= '0;
            gid_q  <= '0;
        end else if (can_load) begin
            vld_q <= acc;
            if (acc) begin
                op_q   <= win_op;
                ch_q   <= win_ch;
                rob_q  <= win_rob;
                set_q  <= win_set;
                way_q  <= win_way;
                wbuf_q <= win_wbuf;
                gid_q  <= gnt_idx;
            end
        end
    end

    assign d_rc_valid           = vld_q;
    assign d_rc_op              = op_q;
    assign d_rc_channel_1hot_id = ch_q;
    assign d_rc_rob_id          = rob_q;
    assign d_rc_set             = set_q;
    assign d_rc_way             = way_q;
    assign d_rc_wbuf_id         = wbuf_q;
    assign d_rc_grant_id        = gid_q;
    assign crdt_avail           = crdt_q;
    assign crdt_err             = crdt_err_q;

`ifdef MPC_RC_ARB_PERF_EN
    logic [NumReq-1:0][15:0] stall_q;

    // Count cycles each requester waits with a valid request, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (req_valid[i] && !req_ready[i] && stall_q[i] != 16'hFFFF)
                    stall_q[i] <= stall_q[i] + 16'd1;
            end
        end
    end

    assign perf_stall_cnt = stall_q;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule
